fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with single outstanding request, redirect, kill and fault halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  input  logic        take,
  input  logic [31:0] nextPC,
  input  logic        stall,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  output logic        fetchFault
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_kill, w_kill_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_instr_pc, w_instr_pc_nxt;
  logic        r_fault, w_fault_nxt;

  logic w_slot_free;
  logic w_req;
  logic w_grant;
  logic w_aligned;
  logic w_pending;
  logic w_outstanding_after;

  // Request gating: one request at a time, and only when the output slot drains this cycle.
  // r_pc is the address of the request being offered or awaited, so it doubles as imemAddr.
  // A request is pending in WAIT, and in HALT when a killed response is still due.
  always_comb begin
    w_slot_free         = !r_valid || !stall;
    w_req               = !rst && (r_state == S_REQ) && w_slot_free;
    w_grant             = w_req && imemGnt;
    w_aligned           = (nextPC[1:0] == 2'b00);
    w_pending           = (r_state == S_WAIT) || ((r_state == S_HALT) && r_kill);
    w_outstanding_after = w_grant || (w_pending && !imemRvalid);
  end

  // Next-state logic: redirect beats stall and any same-cycle response.
  // A redirect that leaves a request in flight parks in WAIT with kill set,
  // so the stale response is drained before the new address is requested.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_kill_nxt     = r_kill;
    w_valid_nxt    = r_valid;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_fault_nxt    = r_fault;
    if (take) begin
      w_valid_nxt = 1'b0;
      w_kill_nxt  = w_outstanding_after;
      if (w_aligned) begin
        w_pc_nxt    = nextPC;
        w_fault_nxt = 1'b0;
        w_state_nxt = w_outstanding_after ? S_WAIT : S_REQ;
      end else begin
        w_fault_nxt = 1'b1;
        w_state_nxt = S_HALT;
      end
    end else begin
      if (r_valid && !stall) begin
        w_valid_nxt = 1'b0;
      end
      unique case (r_state)
        S_REQ: begin
          if (w_grant) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imemRvalid) begin
            w_state_nxt = S_REQ;
            w_kill_nxt  = 1'b0;
            if (!r_kill) begin
              w_valid_nxt    = 1'b1;
              w_instr_nxt    = imemRdata;
              w_instr_pc_nxt = r_pc;
              w_pc_nxt       = r_pc + 32'd4;
            end
          end
        end
        S_HALT: begin
          if (imemRvalid) begin
            w_kill_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_REQ;
        end
      endcase
    end
  end

  // State register with synchronous reset back to the reset fetch address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_instr_pc <= 32'd0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_valid    <= w_valid_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  always_comb begin
    imemReq    = w_req;
    imemAddr   = r_pc;
    instrValid = r_valid && !rst;
    instr      = rst ? 32'd0 : r_instr;
    instrPC    = rst ? 32'd0 : r_instr_pc;
    fetchFault = r_fault && !rst;
  end

endmodule
